// File: rtl/ex_muldiv_iter.sv
// Iterative multiply/divide unit beside the EX-stage ALU: shift-add multiply and
// restoring divide, BPC bits per cycle, producing HI/LO write data.
module ex_muldiv_iter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned BPC   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] opdata1_i,
  input  logic [WIDTH-1:0] opdata2_i,
  input  logic             annul_i,
  output logic             ready_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             stallreq_o
);

  localparam int unsigned N  = WIDTH / BPC;
  localparam int unsigned CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             is_div;
  logic             dbz;
  logic             neg_res;
  logic             neg_rem;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH:0]   acc_hi;
  logic [WIDTH-1:0] acc_lo;

  // Operand decode at acceptance
  logic             signed_op;
  logic             div_op;
  logic             sign_a;
  logic             sign_b;
  logic             div_zero;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;

  assign signed_op = ~op_i[0];
  assign div_op    = op_i[1];
  assign sign_a    = signed_op & opdata1_i[WIDTH-1];
  assign sign_b    = signed_op & opdata2_i[WIDTH-1];
  assign div_zero  = div_op & (opdata2_i == '0);
  assign abs_a     = sign_a ? -opdata1_i : opdata1_i;
  assign abs_b     = sign_b ? -opdata2_i : opdata2_i;

  assign stallreq_o = start_i & ~ready_o & ~annul_i;

  // One CALC cycle: BPC iterations of shift-add or restoring-divide
  logic [WIDTH:0]   step_hi;
  logic [WIDTH-1:0] step_lo;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   trial;

  always_comb begin
    step_hi = acc_hi;
    step_lo = acc_lo;
    sum     = '0;
    trial   = '0;
    for (int i = 0; i < int'(BPC); i++) begin
      if (is_div) begin
        trial   = {step_hi[WIDTH-1:0], step_lo[WIDTH-1]};
        step_lo = {step_lo[WIDTH-2:0], 1'b0};
        if (trial >= {1'b0, mag_b}) begin
          trial      = trial - {1'b0, mag_b};
          step_lo[0] = 1'b1;
        end
        step_hi = trial;
      end else begin
        sum     = step_lo[0] ? (step_hi + {1'b0, mag_a}) : step_hi;
        step_lo = {sum[0], step_lo[WIDTH-1:1]};
        step_hi = {1'b0, sum[WIDTH:1]};
      end
    end
  end

  // Sign fixup on the magnitudes; product kept at full 2*WIDTH
  logic [2*WIDTH-1:0] prod_mag;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;

  always_comb begin
    prod_mag = {acc_hi[WIDTH-1:0], acc_lo};
    prod     = neg_res ? -prod_mag : prod_mag;
    quo      = neg_res ? -acc_lo : acc_lo;
    rem      = neg_rem ? -acc_hi[WIDTH-1:0] : acc_hi[WIDTH-1:0];
    if (dbz) begin
      res_hi = acc_lo;
      res_lo = '1;
    end else if (is_div) begin
      res_hi = rem;
      res_lo = quo;
    end else begin
      res_hi = prod[2*WIDTH-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
    end
  end

  // Control FSM with registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      is_div  <= 1'b0;
      dbz     <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      mag_a   <= '0;
      mag_b   <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      ready_o <= 1'b0;
      hi_o    <= '0;
      lo_o    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i && !annul_i) begin
            mag_a   <= abs_a;
            mag_b   <= abs_b;
            is_div  <= div_op;
            dbz     <= div_zero;
            neg_res <= sign_a ^ sign_b;
            neg_rem <= sign_a;
            acc_hi  <= '0;
            // Divide-by-zero skips the iterations and passes the dividend through
            acc_lo  <= div_zero ? opdata1_i : (div_op ? abs_a : abs_b);
            cnt     <= div_zero ? CW'(N) : '0;
            state   <= CALC;
          end
        end
        CALC: begin
          if (annul_i || !start_i) begin
            state   <= IDLE;
            ready_o <= 1'b0;
            hi_o    <= '0;
            lo_o    <= '0;
          end else if (cnt == CW'(N)) begin
            state   <= DONE;
            ready_o <= 1'b1;
            hi_o    <= res_hi;
            lo_o    <= res_lo;
          end else begin
            acc_hi <= step_hi;
            acc_lo <= step_lo;
            cnt    <= cnt + CW'(1);
          end
        end
        DONE: begin
          if (annul_i || !start_i) begin
            state   <= IDLE;
            ready_o <= 1'b0;
            hi_o    <= '0;
            lo_o    <= '0;
          end
        end
        default: begin
          state   <= IDLE;
          ready_o <= 1'b0;
          hi_o    <= '0;
          lo_o    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv_iter.sv
// Scoreboard bench for ex_muldiv_iter: three instances (BPC 1/2/4) driven in turn,
// results compared against a plain-arithmetic reference model.
module tb_ex_muldiv_iter;

  typedef struct {
    int          inst;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
    int          acc;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        st[3];
  logic        an[3];
  logic        rdy[3];
  logic        stall[3];
  logic [1:0]  op[3];
  logic [31:0] a[3];
  logic [31:0] b[3];
  logic [31:0] hi[3];
  logic [31:0] lo[3];

  exp_t sbq[$];
  int   cyc = 0;
  int   nvec = 0;
  int   nerr = 0;
  bit   rdy_q[3];

  ex_muldiv_iter #(.WIDTH(32), .BPC(1)) u_b1 (
    .clk(clk), .rst(rst), .start_i(st[0]), .op_i(op[0]), .opdata1_i(a[0]), .opdata2_i(b[0]),
    .annul_i(an[0]), .ready_o(rdy[0]), .hi_o(hi[0]), .lo_o(lo[0]), .stallreq_o(stall[0]));
  ex_muldiv_iter #(.WIDTH(32), .BPC(2)) u_b2 (
    .clk(clk), .rst(rst), .start_i(st[1]), .op_i(op[1]), .opdata1_i(a[1]), .opdata2_i(b[1]),
    .annul_i(an[1]), .ready_o(rdy[1]), .hi_o(hi[1]), .lo_o(lo[1]), .stallreq_o(stall[1]));
  ex_muldiv_iter #(.WIDTH(32), .BPC(4)) u_b4 (
    .clk(clk), .rst(rst), .start_i(st[2]), .op_i(op[2]), .opdata1_i(a[2]), .opdata2_i(b[2]),
    .annul_i(an[2]), .ready_o(rdy[2]), .hi_o(hi[2]), .lo_o(lo[2]), .stallreq_o(stall[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void cmp(input string nm, input logic [31:0] act, input logic [31:0] expv);
    nvec++;
    if (act !== expv) begin
      nerr++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", nm, act, expv, cyc);
    end
  endfunction

  function automatic int nk(input int k);
    return (k == 0) ? 32 : (k == 1) ? 16 : 8;
  endfunction

  // Reference: {hi, lo} from plain 64-bit arithmetic
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint          sx, sy, sq, sr;
    longint unsigned ux, uy, p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = 64'(x);
    uy = 64'(y);
    case (o)
      2'b00: p = 64'(sx * sy);
      2'b01: p = ux * uy;
      default: begin
        if (y == 32'd0) p = {x, 32'hFFFF_FFFF};
        else if (o == 2'b10) begin
          sq = sx / sy;
          sr = sx % sy;
          p  = {sr[31:0], sq[31:0]};
        end else p = {32'(ux % uy), 32'(ux / uy)};
      end
    endcase
    return p;
  endfunction

  task automatic push_exp(input int k, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t        e;
    logic [63:0] r;
    r     = model(o, x, y);
    e.inst = k;
    e.hi   = r[63:32];
    e.lo   = r[31:0];
    e.lat  = (o[1] && y == 32'd0) ? 1 : nk(k) + 1;
    e.acc  = cyc + 1;
    sbq.push_back(e);
  endtask

  task automatic chk_stall(input int k);
    cmp("stallreq", 32'(stall[k]), 32'(st[k] & ~rdy[k] & ~an[k]));
  endtask

  // Issue one operation; annul_at >= 0 aborts it that many cycles after acceptance
  task automatic run_op(input int k, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input int annul_at);
    bit done;
    int hold;
    @(negedge clk);
    st[k] = 1'b1; op[k] = o; a[k] = x; b[k] = y; an[k] = 1'b0;
    if (annul_at < 0) push_exp(k, o, x, y);
    #1 chk_stall(k);
    done = 1'b0;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      if (rdy[k]) done = 1'b1;
      else begin
        op[k] = 2'($urandom); a[k] = $urandom; b[k] = $urandom;
        if (annul_at >= 0 && n == annul_at) an[k] = 1'b1;
        else if (annul_at >= 0 && n == annul_at + 1) begin
          an[k] = 1'b0; st[k] = 1'b0; done = 1'b1;
        end
        #1 chk_stall(k);
      end
    end
    if (!done) begin
      nvec++; nerr++;
      $display("FAIL timeout: inst %0d got no ready within 200 cycles", k);
      st[k] = 1'b0; an[k] = 1'b0;
    end else if (annul_at >= 0) begin
      cmp("annul_ready", 32'(rdy[k]), 32'd0);
      cmp("annul_hi", hi[k], 32'd0);
      cmp("annul_lo", lo[k], 32'd0);
    end else begin
      hold = $urandom_range(0, 2);
      repeat (hold) begin
        @(negedge clk);
        cmp("hold_ready", 32'(rdy[k]), 32'd1);
        #1 chk_stall(k);
      end
      st[k] = 1'b0;
      @(negedge clk);
      cmp("clear_ready", 32'(rdy[k]), 32'd0);
      cmp("clear_hi", hi[k], 32'd0);
      cmp("clear_lo", lo[k], 32'd0);
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  // Monitor: every rising ready pops the scoreboard
  always @(negedge clk) begin
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      if (rst && rdy[k] && !rdy_q[k]) begin
        if (sbq.size() == 0) begin
          nvec++; nerr++;
          $display("FAIL spurious_ready: inst %0d got ready=1 required no result", k);
        end else begin
          e = sbq.pop_front();
          cmp("inst", 32'(k), 32'(e.inst));
          cmp("hi", hi[k], e.hi);
          cmp("lo", lo[k], e.lo);
          cmp("latency", 32'(cyc - e.acc), 32'(e.lat));
        end
      end
      rdy_q[k] = rdy[k];
    end
  end

  initial begin
    int          k;
    int          an_at;
    logic [1:0]  o;
    logic [31:0] x, y;
    bit          got;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      st[i] = 1'b0; an[i] = 1'b0; op[i] = 2'b00; a[i] = '0; b[i] = '0; rdy_q[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      cmp("rst_ready", 32'(rdy[i]), 32'd0);
      cmp("rst_hi", hi[i], 32'd0);
      cmp("rst_lo", lo[i], 32'd0);
      cmp("rst_stall", 32'(stall[i]), 32'd0);
    end
    rst = 1'b1;

    // Directed cases
    run_op(0, 2'b00, 32'hFFFF_FFFD, 32'd7, -1);
    run_op(0, 2'b10, 32'hFFFF_FFF9, 32'd2, -1);
    run_op(0, 2'b11, 32'd100, 32'd7, -1);
    run_op(0, 2'b10, 32'h0000_1234, 32'd0, -1);
    run_op(0, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, -1);
    run_op(0, 2'b00, 32'h8000_0000, 32'h8000_0000, -1);
    run_op(2, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
    run_op(1, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
    run_op(1, 2'b10, 32'h8000_0001, 32'h0000_0003, -1);
    run_op(2, 2'b00, 32'h1234_5678, 32'hFEDC_BA98, -1);

    // Annul mid-CALC, then a fresh start two cycles later
    run_op(0, 2'b00, 32'd123, 32'd456, 10);
    @(negedge clk);
    run_op(0, 2'b00, 32'hFFFF_FF85, 32'd456, -1);

    // Reset while holding a result in DONE
    @(negedge clk);
    st[0] = 1'b1; op[0] = 2'b01; a[0] = 32'd5; b[0] = 32'd6; an[0] = 1'b0;
    push_exp(0, 2'b01, 32'd5, 32'd6);
    got = 1'b0;
    for (int n = 0; n < 100 && !got; n++) begin
      @(negedge clk);
      got = rdy[0];
    end
    cmp("pre_rst_ready", 32'(got), 32'd1);
    #2 rst = 1'b0; st[0] = 1'b0;
    #1;
    cmp("async_rst_ready", 32'(rdy[0]), 32'd0);
    cmp("async_rst_hi", hi[0], 32'd0);
    cmp("async_rst_lo", lo[0], 32'd0);
    cmp("async_rst_stall", 32'(stall[0]), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Reset in the middle of CALC: no result may appear afterwards
    @(negedge clk);
    st[0] = 1'b1; op[0] = 2'b00; a[0] = 32'd9; b[0] = 32'd9;
    repeat (5) @(negedge clk);
    #2 rst = 1'b0; st[0] = 1'b0;
    #1;
    cmp("calc_rst_ready", 32'(rdy[0]), 32'd0);
    cmp("calc_rst_stall", 32'(stall[0]), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    cmp("post_rst_idle", 32'(rdy[0]), 32'd0);
    run_op(0, 2'b10, 32'd1000, 32'hFFFF_FFF9, -1);

    // Randomized operations across all three instances
    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(0, 2);
      o = 2'($urandom);
      x = pick();
      y = pick();
      an_at = -1;
      if (!(o[1] && y == 32'd0) && $urandom_range(0, 7) == 0) an_at = $urandom_range(0, 5);
      run_op(k, o, x, y, an_at);
    end

    repeat (4) @(negedge clk);
    cmp("scoreboard_empty", 32'(sbq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
